mesi_bus_ctrl: RTL and testbench

Upstream request stage for the two-cache MESI protocol block. It accepts read/write requests from two processor ports, serializes them with a round-robin arbiter, and looks up the line state in both caches. It then encodes one one-cycle transaction pulse on the per-cache processor and bus signals that the MESI protocol block consumes. This replaces hand-driven bus stimulus with a controller that is correct by construction.

---
 rtl/mesi_pkg.sv | 70 +++++++
 rtl/mesi_bus_ctrl_if.sv | 37 +++
 rtl/rr_arb2.sv | 36 +++
 rtl/mesi_bus_ctrl.sv | 151 +++++++++++++++
 tb/tb_mesi_bus_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesi_pkg.sv
// Shared types for the MESI request stage: line-state codes, controller
// FSM encoding, the per-cache transaction pulse bundle and its encoder.
package mesi_pkg;

   typedef enum logic [1:0] {
      ST_I = 2'd0,
      ST_S = 2'd1,
      ST_E = 2'd2,
      ST_M = 2'd3
   } mesi_st_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      ISSUE  = 2'd2,
      GAP    = 2'd3
   } ctrl_state_e;

   // Field order is shared with the protocol block; MSB first.
   typedef struct packed {
      logic pr_rd;
      logic pr_wr;
      logic bus_rd_c;
      logic bus_rd_ic;
      logic bus_rdx;
      logic bus_upgr;
      logic flush;
      logic flush_opt;
   } txn_pulse_t;

   localparam txn_pulse_t TXN_NONE = '0;

   // Pulse set for one requester given its own line state and the other
   // cache's line state.
   function automatic txn_pulse_t encode_txn(input logic wr, input mesi_st_e own,
                                             input mesi_st_e oth);
      txn_pulse_t p;
      p = TXN_NONE;
      if (!wr) begin
         p.pr_rd = 1'b1;
         if (own == ST_I) begin
            if (oth == ST_I) begin
               p.bus_rd_ic = 1'b1;
            end else begin
               p.bus_rd_c = 1'b1;
               if (oth == ST_M) p.flush = 1'b1;
               else             p.flush_opt = 1'b1;
            end
         end
      end else begin
         p.pr_wr = 1'b1;
         case (own)
            ST_M: ;
            ST_E, ST_S: p.bus_upgr = 1'b1;
            default: begin
               p.bus_rdx = 1'b1;
               if (oth == ST_M)      p.flush = 1'b1;
               else if (oth != ST_I) p.flush_opt = 1'b1;
            end
         endcase
      end
      return p;
   endfunction

   // Two caches can never both hold a line exclusively.
   function automatic logic is_illegal_pair(input mesi_st_e a, input mesi_st_e b);
      return ((a == ST_M) || (a == ST_E)) && ((b == ST_M) || (b == ST_E));
   endfunction

endpackage

// File: rtl/mesi_bus_ctrl_if.sv
// Request, lookup and transaction-pulse signals between the two cores,
// the two caches' state arrays and the MESI request controller.
interface mesi_bus_ctrl_if #(parameter int ADDR_W = 32);

   logic              req_valid_1, req_valid_2;
   logic              req_wr_1, req_wr_2;
   logic [ADDR_W-1:0] req_addr_1, req_addr_2;
   logic              req_ready_1, req_ready_2;
   logic              done_1, done_2;
   logic [ADDR_W-1:0] lookup_addr;
   logic [1:0]        st_1, st_2;
   logic Pr_Rd_1, Pr_Wr_1, Bus_Rd_C_1, Bus_Rd_IC_1, Bus_RdX_1, Bus_Upgr_1, Flush_1, Flush_Opt_1;
   logic Pr_Rd_2, Pr_Wr_2, Bus_Rd_C_2, Bus_Rd_IC_2, Bus_RdX_2, Bus_Upgr_2, Flush_2, Flush_Opt_2;
   logic [ADDR_W-1:0] effective_address_1, effective_address_2;
   logic [1:0]        Cache1_pointer, Cache2_pointer;

   // Controller side.
   modport master (
      input  req_valid_1, req_valid_2, req_wr_1, req_wr_2, req_addr_1, req_addr_2,
      input  st_1, st_2,
      output req_ready_1, req_ready_2, done_1, done_2, lookup_addr,
      output Pr_Rd_1, Pr_Wr_1, Bus_Rd_C_1, Bus_Rd_IC_1, Bus_RdX_1, Bus_Upgr_1, Flush_1, Flush_Opt_1,
      output Pr_Rd_2, Pr_Wr_2, Bus_Rd_C_2, Bus_Rd_IC_2, Bus_RdX_2, Bus_Upgr_2, Flush_2, Flush_Opt_2,
      output effective_address_1, effective_address_2, Cache1_pointer, Cache2_pointer
   );

   // Cores / caches / protocol block side.
   modport slave (
      output req_valid_1, req_valid_2, req_wr_1, req_wr_2, req_addr_1, req_addr_2,
      output st_1, st_2,
      input  req_ready_1, req_ready_2, done_1, done_2, lookup_addr,
      input  Pr_Rd_1, Pr_Wr_1, Bus_Rd_C_1, Bus_Rd_IC_1, Bus_RdX_1, Bus_Upgr_1, Flush_1, Flush_Opt_1,
      input  Pr_Rd_2, Pr_Wr_2, Bus_Rd_C_2, Bus_Rd_IC_2, Bus_RdX_2, Bus_Upgr_2, Flush_2, Flush_Opt_2,
      input  effective_address_1, effective_address_2, Cache1_pointer, Cache2_pointer
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. last_grant holds 1 or 2 (the core that
// won most recently); it resets to 2 so core 1 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       grant_valid
);

   logic [1:0] last_grant_q, last_grant_d;
   logic [1:0] grant_c;

   // Tie goes to whoever did not win last; a lone requester always wins.
   always_comb begin
      grant_c      = 2'b00;
      last_grant_d = last_grant_q;
      if (en) begin
         if (req == 2'b11) grant_c = (last_grant_q == 2'd1) ? 2'b10 : 2'b01;
         else              grant_c = req;
      end
      if (grant_c[0])      last_grant_d = 2'd1;
      else if (grant_c[1]) last_grant_d = 2'd2;
   end

   // Remember the most recent winner.
   always_ff @(posedge clk) begin
      if (rst) last_grant_q <= 2'd2;
      else     last_grant_q <= last_grant_d;
   end

   assign grant       = grant_c;
   assign grant_valid = |grant_c;

endmodule

// File: rtl/mesi_bus_ctrl.sv
// MESI request stage: arbitrates two cores, looks the line up in both
// caches and issues one registered transaction pulse set to the requester.
//
//   state  | meaning
//   IDLE   | wait for a request; accept pulse and latch on grant
//   LOOKUP | lookup_addr presented, both line states sampled, pulses encoded
//   ISSUE  | pulse set and done visible for the requester
//   GAP    | quiet cycle before the next accept
module mesi_bus_ctrl
   import mesi_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   mesi_bus_ctrl_if.master bus
);

   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic              sel_q, sel_d;       // 0 = core 1 is requester, 1 = core 2
   mesi_st_e          own_q, own_d, oth_q, oth_d;
   txn_pulse_t        pulse_1_q, pulse_1_d, pulse_2_q, pulse_2_d;
   logic              done_1_q, done_1_d, done_2_q, done_2_d;
   logic              err_q, err_d;

   logic [1:0]        grant;
   logic              grant_valid;
   logic              arb_en;
   txn_pulse_t        txn;
   mesi_st_e          st_1, st_2;

   assign st_1   = mesi_st_e'(bus.st_1);
   assign st_2   = mesi_st_e'(bus.st_2);
   // A reset cycle must not produce an accept pulse.
   assign arb_en = (state_q == IDLE) && !rst;

   rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .en          (arb_en),
      .req         ({bus.req_valid_2, bus.req_valid_1}),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Next-state, latching and pulse encoding.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      sel_d     = sel_q;
      own_d     = own_q;
      oth_d     = oth_q;
      pulse_1_d = TXN_NONE;
      pulse_2_d = TXN_NONE;
      done_1_d  = 1'b0;
      done_2_d  = 1'b0;
      err_d     = err_q;
      txn       = TXN_NONE;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               sel_d   = grant[1];
               addr_d  = grant[1] ? bus.req_addr_2 : bus.req_addr_1;
               wr_d    = grant[1] ? bus.req_wr_2   : bus.req_wr_1;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            own_d = sel_q ? st_2 : st_1;
            oth_d = sel_q ? st_1 : st_2;
            txn   = encode_txn(wr_q, own_d, oth_d);
            if (sel_q) begin
               pulse_2_d = txn;
               done_2_d  = 1'b1;
            end else begin
               pulse_1_d = txn;
               done_1_d  = 1'b1;
            end
            if (is_illegal_pair(st_1, st_2)) err_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE:   state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All controller state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         sel_q     <= 1'b0;
         own_q     <= ST_I;
         oth_q     <= ST_I;
         pulse_1_q <= TXN_NONE;
         pulse_2_q <= TXN_NONE;
         done_1_q  <= 1'b0;
         done_2_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         sel_q     <= sel_d;
         own_q     <= own_d;
         oth_q     <= oth_d;
         pulse_1_q <= pulse_1_d;
         pulse_2_q <= pulse_2_d;
         done_1_q  <= done_1_d;
         done_2_q  <= done_2_d;
         err_q     <= err_d;
      end
   end

   assign bus.req_ready_1 = grant_valid & grant[0];
   assign bus.req_ready_2 = grant_valid & grant[1];
   assign bus.done_1      = done_1_q;
   assign bus.done_2      = done_2_q;

   // The latched address doubles as lookup and effective address; all hold
   // between transactions.
   assign bus.lookup_addr         = addr_q;
   assign bus.effective_address_1 = addr_q;
   assign bus.effective_address_2 = addr_q;
   assign bus.Cache1_pointer      = addr_q[1:0];
   assign bus.Cache2_pointer      = addr_q[1:0];

   assign bus.Pr_Rd_1     = pulse_1_q.pr_rd;
   assign bus.Pr_Wr_1     = pulse_1_q.pr_wr;
   assign bus.Bus_Rd_C_1  = pulse_1_q.bus_rd_c;
   assign bus.Bus_Rd_IC_1 = pulse_1_q.bus_rd_ic;
   assign bus.Bus_RdX_1   = pulse_1_q.bus_rdx;
   assign bus.Bus_Upgr_1  = pulse_1_q.bus_upgr;
   assign bus.Flush_1     = pulse_1_q.flush;
   assign bus.Flush_Opt_1 = pulse_1_q.flush_opt;

   assign bus.Pr_Rd_2     = pulse_2_q.pr_rd;
   assign bus.Pr_Wr_2     = pulse_2_q.pr_wr;
   assign bus.Bus_Rd_C_2  = pulse_2_q.bus_rd_c;
   assign bus.Bus_Rd_IC_2 = pulse_2_q.bus_rd_ic;
   assign bus.Bus_RdX_2   = pulse_2_q.bus_rdx;
   assign bus.Bus_Upgr_2  = pulse_2_q.bus_upgr;
   assign bus.Flush_2     = pulse_2_q.flush;
   assign bus.Flush_Opt_2 = pulse_2_q.flush_opt;

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Bench for mesi_bus_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model with a small cache-state model.
module tb_mesi_bus_ctrl;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mesi_bus_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
   mesi_bus_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Cache line states (I=0 S=1 E=2 M=3), indexed by address[3:0].
   logic [1:0] c1 [16];
   logic [1:0] c2 [16];
   assign bus.st_1 = c1[bus.lookup_addr[3:0]];
   assign bus.st_2 = c2[bus.lookup_addr[3:0]];

   // {Pr_Rd, Pr_Wr, Bus_Rd_C, Bus_Rd_IC, Bus_RdX, Bus_Upgr, Flush, Flush_Opt}
   wire [7:0] p1_vec = {bus.Pr_Rd_1, bus.Pr_Wr_1, bus.Bus_Rd_C_1, bus.Bus_Rd_IC_1,
                        bus.Bus_RdX_1, bus.Bus_Upgr_1, bus.Flush_1, bus.Flush_Opt_1};
   wire [7:0] p2_vec = {bus.Pr_Rd_2, bus.Pr_Wr_2, bus.Bus_Rd_C_2, bus.Bus_Rd_IC_2,
                        bus.Bus_RdX_2, bus.Bus_Upgr_2, bus.Flush_2, bus.Flush_Opt_2};

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int obs[$];      // cyc*1024 + core*256 + pulse vector, one per done
   int rdy_log[$];  // cyc*4 + core, one per accept

   // model state
   int          m_last = 2;
   int          m_busy_until = 0;
   bit          m_pend = 0;
   int          m_r = 0;
   logic        m_wr = 1'b0;
   logic [31:0] m_addr = '0;
   int          m_acc = 0;
   logic [7:0]  m_txn = '0;
   logic [31:0] m_eaddr = '0;
   logic        m_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model_enc(input logic wr, input logic [1:0] own,
                                            input logic [1:0] oth);
      logic [7:0] v;
      bit hit   = (own != 2'd0);
      bit dirty = (oth == 2'd3);
      bit clean = (oth == 2'd1) || (oth == 2'd2);
      if (!wr) begin
         v = 8'h80;
         if (!hit) begin
            v = v | ((dirty || clean) ? 8'h20 : 8'h10);
            if (dirty) v = v | 8'h02;
            if (clean) v = v | 8'h01;
         end
      end else begin
         v = 8'h40;
         if (own == 2'd3) v = v;
         else if (hit)    v = v | 8'h04;
         else begin
            v = v | 8'h08;
            if (dirty) v = v | 8'h02;
            if (clean) v = v | 8'h01;
         end
      end
      return v;
   endfunction

   // Per-cycle model step and comparison, sampled on the falling edge.
   initial begin
      logic e_r1, e_r2, e_d1, e_d2;
      logic [7:0] e_p1, e_p2;
      logic [1:0] own, oth, n_own, n_oth;
      int g, a;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         g = 0;
         if (!rst && cyc >= m_busy_until && (bus.req_valid_1 || bus.req_valid_2)) begin
            if (bus.req_valid_1 && bus.req_valid_2) g = (m_last == 1) ? 2 : 1;
            else                                   g = bus.req_valid_1 ? 1 : 2;
         end
         e_r1 = (g == 1);
         e_r2 = (g == 2);
         e_p1 = '0; e_p2 = '0; e_d1 = 1'b0; e_d2 = 1'b0;
         if (m_pend && cyc == m_acc + 2) begin
            if (m_r == 1) begin e_p1 = m_txn; e_d1 = 1'b1; end
            else          begin e_p2 = m_txn; e_d2 = 1'b1; end
         end
         chk("req_ready_1", bus.req_ready_1, e_r1);
         chk("req_ready_2", bus.req_ready_2, e_r2);
         chk("pulses_1", p1_vec, e_p1);
         chk("pulses_2", p2_vec, e_p2);
         chk("done_1", bus.done_1, e_d1);
         chk("done_2", bus.done_2, e_d2);
         chk("effective_address_1", bus.effective_address_1, m_eaddr);
         chk("effective_address_2", bus.effective_address_2, m_eaddr);
         chk("lookup_addr", bus.lookup_addr, m_eaddr);
         chk("Cache1_pointer", bus.Cache1_pointer, m_eaddr[1:0]);
         chk("Cache2_pointer", bus.Cache2_pointer, m_eaddr[1:0]);
         chk("err", dut.err_q, m_err);

         if (bus.done_1) obs.push_back(cyc * 1024 + 256 + int'(p1_vec));
         if (bus.done_2) obs.push_back(cyc * 1024 + 512 + int'(p2_vec));
         if (bus.req_ready_1) rdy_log.push_back(cyc * 4 + 1);
         if (bus.req_ready_2) rdy_log.push_back(cyc * 4 + 2);

         if (rst) begin
            m_pend = 0; m_eaddr = '0; m_err = 1'b0; m_last = 2; m_busy_until = cyc + 1;
         end else begin
            if (m_pend && cyc == m_acc + 2) begin
               a   = int'(m_addr[3:0]);
               own = (m_r == 1) ? c1[a] : c2[a];
               oth = (m_r == 1) ? c2[a] : c1[a];
               n_own = own; n_oth = oth;
               if (m_wr) begin n_own = 2'd3; n_oth = 2'd0; end
               else if (own == 2'd0) begin
                  if (oth == 2'd0) n_own = 2'd2;
                  else begin n_own = 2'd1; n_oth = 2'd1; end
               end
               if (m_r == 1) begin c1[a] = n_own; c2[a] = n_oth; end
               else          begin c2[a] = n_own; c1[a] = n_oth; end
               m_pend = 0;
            end
            if (m_pend && cyc == m_acc + 1) begin
               a   = int'(m_addr[3:0]);
               own = (m_r == 1) ? c1[a] : c2[a];
               oth = (m_r == 1) ? c2[a] : c1[a];
               m_txn = model_enc(m_wr, own, oth);
               if (c1[a] >= 2'd2 && c2[a] >= 2'd2) m_err = 1'b1;
            end
            if (g != 0) begin
               m_pend = 1; m_r = g; m_acc = cyc; m_busy_until = cyc + 4; m_last = g;
               m_wr   = (g == 1) ? bus.req_wr_1 : bus.req_wr_2;
               m_addr = (g == 1) ? bus.req_addr_1 : bus.req_addr_2;
               m_eaddr = m_addr;
            end
         end
      end
   end

   task automatic set_req(input int core, input logic v, input logic wr, input logic [31:0] addr);
      if (core == 1) begin bus.req_valid_1 = v; bus.req_wr_1 = wr; bus.req_addr_1 = addr; end
      else           begin bus.req_valid_2 = v; bus.req_wr_2 = wr; bus.req_addr_2 = addr; end
   endtask

   // Present one request, hold it until accepted, then drop it.
   task automatic do_req(input int core, input logic wr, input logic [31:0] addr);
      bit got = 0;
      @(posedge clk); #1;
      set_req(core, 1'b1, wr, addr);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (core == 1) ? bus.req_ready_1 : bus.req_ready_2;
      end
      chk("accept_within_bound", got, 1'b1);
      @(posedge clk); #1;
      if (core == 1) bus.req_valid_1 = 1'b0;
      else           bus.req_valid_2 = 1'b0;
   endtask

   task automatic random_phase(input int ncyc);
      logic a1, a2;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         a1 = bus.req_ready_1;
         a2 = bus.req_ready_2;
         @(posedge clk); #1;
         if (bus.req_valid_1) begin
            if (a1 || $urandom_range(0, 19) == 0) bus.req_valid_1 = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            set_req(1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 13)));
         end
         if (bus.req_valid_2) begin
            if (a2 || $urandom_range(0, 19) == 0) bus.req_valid_2 = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            set_req(2, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 13)));
         end
      end
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit r1, r2;
      int seq_exp [5];
      for (int i = 0; i < 16; i++) begin c1[i] = 2'd0; c2[i] = 2'd0; end
      set_req(1, 1'b0, 1'b0, '0);
      set_req(2, 1'b0, 1'b0, '0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_effective_address_1", bus.effective_address_1, 32'd0);
      chk("reset_done_1", bus.done_1, 1'b0);

      // Both cores held valid: grants 1, 2, 1 spaced 4 cycles.
      rdy_log.delete();
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b0, 32'd1);
      set_req(2, 1'b1, 1'b0, 32'd2);
      n = 0;
      for (int i = 0; i < 40 && n < 3; i++) begin
         @(negedge clk);
         if (bus.req_ready_1 || bus.req_ready_2) n++;
      end
      @(posedge clk); #1;
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b0;
      chk("tie_accept_count", rdy_log.size(), 3);
      if (rdy_log.size() == 3) begin
         chk("tie_grant_0", rdy_log[0] % 4, 1);
         chk("tie_grant_1", rdy_log[1] % 4, 2);
         chk("tie_grant_2", rdy_log[2] % 4, 1);
         chk("tie_spacing_01", rdy_log[1] / 4 - rdy_log[0] / 4, 4);
         chk("tie_spacing_12", rdy_log[2] / 4 - rdy_log[1] / 4, 4);
      end
      repeat (6) @(posedge clk);

      // R1, W1, R2, W2, R1 at address 5.
      obs.delete();
      do_req(1, 1'b0, 32'd5);
      do_req(1, 1'b1, 32'd5);
      do_req(2, 1'b0, 32'd5);
      do_req(2, 1'b1, 32'd5);
      do_req(1, 1'b0, 32'd5);
      repeat (6) @(posedge clk);
      seq_exp[0] = 256 + 8'h90;
      seq_exp[1] = 256 + 8'h44;
      seq_exp[2] = 512 + 8'hA2;
      seq_exp[3] = 512 + 8'h44;
      seq_exp[4] = 256 + 8'hA2;
      chk("seq_count", obs.size(), 5);
      if (obs.size() == 5)
         for (int k = 0; k < 5; k++) chk("seq_pulse", obs[k] % 1024, seq_exp[k]);
      chk("seq_pointer", bus.Cache1_pointer, 2'd1);

      // Read hit with st_1 = S.
      c1[3] = 2'd1; c2[3] = 2'd0;
      obs.delete(); rdy_log.delete();
      do_req(1, 1'b0, 32'd3);
      repeat (6) @(posedge clk);
      chk("hit_count", obs.size(), 1);
      if (obs.size() == 1 && rdy_log.size() == 1) begin
         chk("hit_pulse", obs[0] % 1024, 256 + 8'h80);
         chk("hit_done_latency", obs[0] / 1024 - rdy_log[0] / 4, 2);
      end

      // Write miss, other cache E, address 0xA.
      c1[10] = 2'd0; c2[10] = 2'd2;
      obs.delete();
      do_req(1, 1'b1, 32'h0000_000A);
      repeat (6) @(posedge clk);
      chk("wmiss_count", obs.size(), 1);
      if (obs.size() == 1) chk("wmiss_pulse", obs[0] % 1024, 256 + 8'h49);
      chk("wmiss_eaddr", bus.effective_address_1, 32'h0000_000A);
      chk("wmiss_pointer", bus.Cache1_pointer, 2'd2);

      // Reset during LOOKUP aborts; core 1 priority returns afterwards.
      obs.delete();
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b0, 32'd7);
      r1 = 0;
      for (int i = 0; i < 20 && !r1; i++) begin @(negedge clk); r1 = bus.req_ready_1; end
      chk("abort_accept", r1, 1'b1);
      @(posedge clk); #1;
      bus.req_valid_1 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(1, 1'b1, 1'b0, 32'd8);
      set_req(2, 1'b1, 1'b0, 32'd9);
      r1 = 0; r2 = 0;
      for (int i = 0; i < 20 && !(r1 || r2); i++) begin
         @(negedge clk);
         r1 = bus.req_ready_1; r2 = bus.req_ready_2;
      end
      chk("prio_after_rst_1", r1, 1'b1);
      chk("prio_after_rst_2", r2, 1'b0);
      @(posedge clk); #1;
      bus.req_valid_1 = 1'b0;
      r2 = 0;
      for (int i = 0; i < 20 && !r2; i++) begin @(negedge clk); r2 = bus.req_ready_2; end
      chk("pending_core2_wins", r2, 1'b1);
      @(posedge clk); #1;
      bus.req_valid_2 = 1'b0;
      repeat (6) @(posedge clk);
      chk("abort_done_count", obs.size(), 2);

      random_phase(400);

      // Illegal M/M pair: encode from own, sticky err until reset.
      c1[14] = 2'd3; c2[14] = 2'd3;
      obs.delete();
      do_req(1, 1'b0, 32'd14);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("err_sticky", dut.err_q, 1'b1);
      chk("illegal_count", obs.size(), 1);
      if (obs.size() == 1) chk("illegal_pulse", obs[0] % 1024, 256 + 8'h80);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", dut.err_q, 1'b0);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
